// File: rtl/axis_stream_sink_bp.sv
`default_nettype none
// ============================================================================
// Module   : axis_stream_sink_bp
// Purpose  : AXI-Stream sink with selectable tready backpressure, show-ahead
//            capture FIFO, beat/packet counters and sticky TID check.
// Revision : 1.0
// ============================================================================
module axis_stream_sink_bp #(
    parameter int          DATA_W    = 8,
    parameter int          USER_W    = 8,
    parameter int          ID_W      = 8,
    parameter int          KEEP_W    = 8,
    parameter int          DEPTH     = 16,
    parameter int          CNT_W     = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       axis_s_tvalid,
    input  logic [DATA_W-1:0]          axis_s_tdata,
    input  logic [USER_W-1:0]          axis_s_tuser,
    input  logic [ID_W-1:0]            axis_s_tid,
    input  logic [KEEP_W-1:0]          axis_s_tkeep,
    input  logic                       axis_s_tlast,
    output logic                       axis_s_tready,
    input  logic [1:0]                 bp_mode,
    input  logic [7:0]                 bp_thresh,
    input  logic                       clr,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,
    output logic [USER_W-1:0]          rd_user,
    output logic [ID_W-1:0]            rd_id,
    output logic [KEEP_W-1:0]          rd_keep,
    output logic                       rd_last,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CNT_W-1:0]           beat_cnt,
    output logic [CNT_W-1:0]           pkt_cnt,
    output logic                       err_tid
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          EW        = DATA_W + USER_W + ID_W + KEEP_W + 1;
    localparam logic [AW:0] FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [1:0] BP_ALWAYS  = 2'b00;
    localparam logic [1:0] BP_RANDOM  = 2'b01;
    localparam logic [1:0] BP_PATTERN = 2'b10;

    logic [EW-1:0]     mem [DEPTH];

    logic              tready_q, tready_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [3:0]        phase_q, phase_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic              in_pkt_q, in_pkt_d;
    logic [ID_W-1:0]   pkt_tid_q, pkt_tid_d;
    logic              err_tid_q, err_tid_d;

    logic              accept;
    logic              pop;
    logic              allow;

    assign rd_valid = (count_q != '0);
    assign accept   = axis_s_tvalid && tready_q;
    assign pop      = rd_valid && rd_ready;

    always_comb begin
        allow = 1'b0;
        case (bp_mode)
            BP_ALWAYS:  allow = 1'b1;
            BP_RANDOM:  allow = (lfsr_q[7:0] < bp_thresh);
            BP_PATTERN: allow = (phase_q < bp_thresh[3:0]);
            default:    allow = 1'b0;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(accept);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW + 1)'(accept) - (AW + 1)'(pop);
        // Ready looks at next-cycle occupancy so a full FIFO can never be overrun.
        tready_d = allow && (count_d < FULL_CNT);
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        phase_d  = phase_q + 4'd1;
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q + CNT_W'(accept);
        pkt_cnt_d  = pkt_cnt_q + CNT_W'(accept && axis_s_tlast);
        err_tid_d  = err_tid_q | (accept && in_pkt_q && (axis_s_tid != pkt_tid_q));
        in_pkt_d   = in_pkt_q;
        pkt_tid_d  = pkt_tid_q;
        if (accept) begin
            in_pkt_d = !axis_s_tlast;
            if (!in_pkt_q) begin
                pkt_tid_d = axis_s_tid;
            end
        end
        if (clr) begin
            beat_cnt_d = '0;
            pkt_cnt_d  = '0;
            err_tid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tready_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lfsr_q     <= LFSR_SEED;
            phase_q    <= '0;
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            in_pkt_q   <= 1'b0;
            pkt_tid_q  <= '0;
            err_tid_q  <= 1'b0;
        end else begin
            tready_q   <= tready_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lfsr_q     <= lfsr_d;
            phase_q    <= phase_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            in_pkt_q   <= in_pkt_d;
            pkt_tid_q  <= pkt_tid_d;
            err_tid_q  <= err_tid_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= {axis_s_tdata, axis_s_tuser, axis_s_tid, axis_s_tkeep, axis_s_tlast};
        end
    end

    assign {rd_data, rd_user, rd_id, rd_keep, rd_last} = mem[rd_ptr_q];

    assign axis_s_tready = tready_q;
    assign fifo_count    = count_q;
    assign beat_cnt      = beat_cnt_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign err_tid       = err_tid_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_stream_sink_bp.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_stream_sink_bp
// Purpose  : Scoreboard bench for axis_stream_sink_bp with directed traffic.
// Revision : 1.0
// ============================================================================
module tb_axis_stream_sink_bp;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] user;
        logic [7:0] id;
        logic [7:0] keep;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tvalid, tlast, tready;
    logic [7:0]  tdata, tuser, tid, tkeep;
    logic [1:0]  bp_mode;
    logic [7:0]  bp_thresh;
    logic        clr;
    logic        rd_valid, rd_ready, rd_last;
    logic [7:0]  rd_data, rd_user, rd_id, rd_keep;
    logic [4:0]  fifo_count;
    logic [31:0] beat_cnt, pkt_cnt;
    logic        err_tid;

    int    checks   = 0;
    int    failures = 0;
    int    src_idx  = 0;
    beat_t exp_q[$];

    // Reference for the backpressure allow term, updated once per clock.
    logic [15:0] m_lfsr;
    logic [3:0]  m_phase;
    logic        m_allow;

    always #5 clk = ~clk;

    axis_stream_sink_bp dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .axis_s_tvalid (tvalid),
        .axis_s_tdata  (tdata),
        .axis_s_tuser  (tuser),
        .axis_s_tid    (tid),
        .axis_s_tkeep  (tkeep),
        .axis_s_tlast  (tlast),
        .axis_s_tready (tready),
        .bp_mode       (bp_mode),
        .bp_thresh     (bp_thresh),
        .clr           (clr),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_user       (rd_user),
        .rd_id         (rd_id),
        .rd_keep       (rd_keep),
        .rd_last       (rd_last),
        .fifo_count    (fifo_count),
        .beat_cnt      (beat_cnt),
        .pkt_cnt       (pkt_cnt),
        .err_tid       (err_tid)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr  <= 16'hACE1;
            m_phase <= 4'd0;
            m_allow <= 1'b0;
        end else begin
            case (bp_mode)
                2'b00:   m_allow <= 1'b1;
                2'b01:   m_allow <= (m_lfsr[7:0] < bp_thresh);
                2'b10:   m_allow <= (m_phase < bp_thresh[3:0]);
                default: m_allow <= 1'b0;
            endcase
            m_lfsr  <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            m_phase <= m_phase + 4'd1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input int idx, input logic [7:0] id, input logic last);
        beat_t b;
        logic [7:0] d;
        d      = 8'(idx);
        b.data = d;
        b.user = d ^ 8'h5A;
        b.id   = id;
        b.keep = ~d;
        b.last = last;
        return b;
    endfunction

    // Monitor: pops the scoreboard whenever the consumer port hands over a beat.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected", {rd_data, rd_user, rd_id, rd_keep, rd_last}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("rd_beat", {rd_data, rd_user, rd_id, rd_keep, rd_last}, exp_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; tready is stable until the next edge.
    task automatic drive_step(input logic vld, input beat_t b, output logic rdy, output logic acc);
        tvalid = vld;
        tdata  = b.data;
        tuser  = b.user;
        tid    = b.id;
        tkeep  = b.keep;
        tlast  = b.last;
        rdy    = tready;
        acc    = vld && rdy;
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back(b);
    endtask

    task automatic send_one(input logic [7:0] id, input logic last);
        logic rdy, acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            drive_step(1'b1, mk(src_idx, id, last), rdy, acc);
            n++;
        end
        chk("send_accepted", acc, 1'b1);
        if (acc) src_idx++;
    endtask

    task automatic idle();
        logic rdy, acc;
        drive_step(1'b0, mk(0, 8'h00, 1'b0), rdy, acc);
    endtask

    task automatic run_valid(input int ncyc, input logic [7:0] id,
                             output int accepts, output int mism);
        logic rdy, acc, exp;
        accepts = 0;
        mism    = 0;
        for (int i = 0; i < ncyc; i++) begin
            exp = m_allow;
            drive_step(1'b1, mk(src_idx, id, 1'b1), rdy, acc);
            if (rdy !== exp) mism++;
            if (acc) begin
                accepts++;
                src_idx++;
            end
        end
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic drain();
        int n;
        rd_ready = 1'b1;
        n = 0;
        while (fifo_count != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("drain_count", fifo_count, 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        int acc_n, mism, ready_n;
        logic rdy, acc;
        rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tuser = '0; tid = '0; tkeep = '0;
        tlast = 1'b0; bp_mode = 2'b00; bp_thresh = 8'd0; clr = 1'b0; rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", tready, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_beat_cnt", beat_cnt, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_err_tid", err_tid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: in-order streaming with two packets
        rd_ready = 1'b1;
        for (int i = 0; i < 20; i++) send_one(8'h01, (i == 3) || (i == 19));
        idle();
        drain();
        chk("t1_beat_cnt", beat_cnt, 20);
        chk("t1_pkt_cnt", pkt_cnt, 2);
        chk("t1_err_tid", err_tid, 1'b0);

        // 2: fill to DEPTH with consumer stalled, then release
        pulse_clr();
        rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_one(8'h02, 1'b1);
        chk("t2_full_count", fifo_count, 16);
        acc_n = 0;
        ready_n = 0;
        for (int i = 0; i < 10; i++) begin
            drive_step(1'b1, mk(src_idx, 8'h02, 1'b1), rdy, acc);
            if (rdy) ready_n++;
            if (acc) begin
                acc_n++;
                src_idx++;
            end
        end
        chk("t2_ready_while_full", ready_n, 0);
        chk("t2_accept_while_full", acc_n, 0);
        chk("t2_hold_count", fifo_count, 16);
        chk("t2_hold_beat_cnt", beat_cnt, 16);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_one(8'h02, 1'b1);
        idle();
        drain();
        chk("t2_beat_cnt", beat_cnt, 24);
        chk("t2_pkt_cnt", pkt_cnt, 24);

        // 3: pattern mode, 4 of every 16 cycles
        bp_mode = 2'b10;
        bp_thresh = 8'd4;
        idle();
        run_valid(64, 8'h03, acc_n, mism);
        chk("t3_accepts", acc_n, 16);
        chk("t3_pattern_seq", mism, 0);

        // 4: random mode at both threshold extremes, then never-ready mode
        bp_mode = 2'b01;
        bp_thresh = 8'd0;
        idle();
        run_valid(100, 8'h04, acc_n, mism);
        chk("t4_thresh0_accepts", acc_n, 0);
        chk("t4_thresh0_seq", mism, 0);
        bp_thresh = 8'd255;
        run_valid(256, 8'h04, acc_n, mism);
        chk("t4_thresh255_ge240", acc_n >= 240, 1'b1);
        chk("t4_lfsr_seq", mism, 0);
        bp_mode = 2'b11;
        idle();
        run_valid(20, 8'h04, acc_n, mism);
        chk("t4_never_accepts", acc_n, 0);
        idle();
        drain();

        // 5: TID mismatch inside a packet, then clear
        bp_mode = 2'b00;
        rd_ready = 1'b0;
        idle();
        pulse_clr();
        send_one(8'h05, 1'b0);
        send_one(8'h05, 1'b0);
        chk("t5_err_before", err_tid, 1'b0);
        send_one(8'h07, 1'b1);
        idle();
        chk("t5_err_tid", err_tid, 1'b1);
        chk("t5_beat_cnt", beat_cnt, 3);
        chk("t5_pkt_cnt", pkt_cnt, 1);
        pulse_clr();
        chk("t5_clr_err", err_tid, 1'b0);
        chk("t5_clr_beat", beat_cnt, 0);
        chk("t5_clr_pkt", pkt_cnt, 0);
        chk("t5_fifo_kept", fifo_count, 3);
        drain();

        // 6: asynchronous reset mid-packet
        rd_ready = 1'b0;
        send_one(8'h09, 1'b0);
        send_one(8'h09, 1'b0);
        tvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_tready_drop", tready, 1'b0);
        chk("t6_rd_valid_drop", rd_valid, 1'b0);
        chk("t6_fifo_count", fifo_count, 0);
        chk("t6_beat_cnt", beat_cnt, 0);
        chk("t6_pkt_cnt", pkt_cnt, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd_ready = 1'b1;
        send_one(8'h3C, 1'b0);
        send_one(8'h3C, 1'b1);
        idle();
        chk("t6_err_tid", err_tid, 1'b0);
        chk("t6_beat_cnt_after", beat_cnt, 2);
        chk("t6_pkt_cnt_after", pkt_cnt, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axis_stream_sink_bp.md
Name: axis_stream_sink_bp

Overview:
Parametrised AXI-Stream sink for bench and in-system traffic checking. It applies a selectable backpressure pattern on tready and buffers accepted beats (data, user, id, keep, last) in a FIFO that a consumer drains through a valid/ready read port. It also keeps beat and packet counters and a sticky TID-consistency error flag.

Parameters:
DATA_W, 8, tdata width
USER_W, 8, tuser width
ID_W, 8, tid width
KEEP_W, 8, tkeep width
DEPTH, 16, capture FIFO entries (power of 2, >=4)
CNT_W, 32, beat counter width (packet counter uses the same width)
LFSR_SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
axis_s_tvalid  in  1  stream valid
axis_s_tdata  in  DATA_W  stream data
axis_s_tuser  in  USER_W  stream user
axis_s_tid  in  ID_W  stream id
axis_s_tkeep  in  KEEP_W  stream keep
axis_s_tlast  in  1  end of packet
axis_s_tready  out  1  registered ready
bp_mode  in  2  00 always, 01 random, 10 pattern, 11 never
bp_thresh  in  8  random/pattern threshold
clr  in  1  synchronous clear of counters and err_tid
rd_valid  out  1  FIFO head valid
rd_ready  in  1  consumer pop
rd_data/rd_user/rd_id/rd_keep/rd_last  out  widths as stream  FIFO head fields
fifo_count  out  $clog2(DEPTH)+1  occupancy
beat_cnt  out  CNT_W  accepted beats
pkt_cnt  out  CNT_W  accepted tlast beats
err_tid  out  1  sticky TID mismatch

Behaviour:
- Reset (async assert, sync deassert by upstream): tready=0, FIFO empty, rd_valid=0, counts=0, err_tid=0, LFSR=LFSR_SEED, phase=0, in_pkt=0.
- Accept: a beat is accepted when tvalid && tready at a clk edge. It is written to the FIFO in the same edge. No combinational input-to-output paths.
- Pop: rd_valid && rd_ready at a clk edge. The FIFO is show-ahead; head fields are valid whenever rd_valid=1 and are undefined otherwise.
- fifo_count_next = fifo_count + accept - pop. Simultaneous accept and pop keeps the count unchanged.
- tready register: tready <= allow && (fifo_count_next < DEPTH). A full FIFO therefore forces tready low the following cycle, and overflow is impossible. Occupancy can reach DEPTH.
- allow, by mode:
  - 00: 1.
  - 01: lfsr[7:0] < bp_thresh. Thresh 0 gives never ready; 255 gives ready 255/256.
  - 10: phase < bp_thresh[3:0].
  - 11: 0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle regardless of mode.
- phase: 4-bit, increments every cycle, wraps 15->0.
- Changing bp_mode takes effect on the next tready update. Beats already accepted are never dropped.
- beat_cnt: +1 per accept.
- pkt_cnt: +1 per accept with tlast.
- Both counters wrap modulo 2^CNT_W.
- Packet tracking: in_pkt is set on an accepted non-last beat, and cleared on an accepted last beat. pkt_tid latches tid on an accepted beat while in_pkt=0.
- err_tid: set when a beat is accepted with in_pkt=1 and tid != pkt_tid. It remains set until clr.
- clr: zeroes beat_cnt, pkt_cnt and err_tid, and has priority over the same-cycle increment. It does not affect the FIFO, in_pkt, LFSR or tready.
- Reset mid-packet: all state is discarded and FIFO contents are lost; in_pkt=0.
- A single-beat packet (tlast on the first beat) never sets in_pkt, and pkt_cnt increments.

Test Plan:
1. mode 00, source drives 20 beats (data 0..19, tlast on 4th and 20th), rd_ready=1 -> data read back in order; beat_cnt=20, pkt_cnt=2, err_tid=0.
2. mode 00, rd_ready=0, source always valid -> exactly 16 beats accepted; tready=0 from the cycle after count reaches 16; fifo_count=16. Then rd_ready=1 -> tready returns and there is no loss or duplication.
3. mode 10, bp_thresh=4, constant tvalid -> tready high exactly 4 of every 16 cycles; 64 cycles yields 16 accepts.
4. mode 01, bp_thresh=0 then 255 -> zero accepts over 100 cycles; then ready on >=240 of 256 cycles. The tready sequence matches a reference LFSR model from seed ACE1.
5. Packet of 3 beats with tid 5,5,7 -> err_tid=1 after the 3rd accept; clr pulse -> err_tid=0 and counters 0, with FIFO still holding 3 beats.
6. Assert rst_n=0 mid-packet for 1 cycle asynchronously -> tready/rd_valid drop immediately and counters are 0. A following packet with new tid accepted -> no err_tid.
